// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_gen
// Brief    : Raster timing generator producing syncs, active/pre-valid strobes,
//            pixel coordinates and a frame counter with frame-aligned start/stop.
// Revision : 1.0
// ============================================================================
module video_timing_gen #(
    parameter int   H_ACTIVE = 1920,
    parameter int   H_FP     = 88,
    parameter int   H_SYNC   = 44,
    parameter int   H_BP     = 148,
    parameter int   V_ACTIVE = 1080,
    parameter int   V_FP     = 4,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 36,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   PRE_LEAD = 1,
    parameter int   COORD_W  = 16,
    parameter int   FRAME_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic               video_hsync_o,
    output logic               video_vsync_o,
    output logic               video_valid_h_o,
    output logic               pre_video_valid_h_o,
    output logic               video_valid_v_o,
    output logic               video_de_o,
    output logic               valid_frame,
    output logic               frame_start_o,
    output logic               line_start_o,
    output logic               running,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int c_H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] c_H_LAST   = COORD_W'(c_H_TOTAL_I - 1);
    localparam logic [COORD_W-1:0] c_V_LAST   = COORD_W'(c_V_TOTAL_I - 1);
    localparam logic [COORD_W-1:0] c_H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] c_V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] c_HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] c_HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] c_VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] c_VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] c_LEAD_H   = COORD_W'(c_H_TOTAL_I - PRE_LEAD);
    localparam logic [COORD_W:0]   c_H_TOTAL_W = (COORD_W+1)'(c_H_TOTAL_I);
    localparam logic [COORD_W:0]   c_LEAD_W    = (COORD_W+1)'(PRE_LEAD);
    localparam logic [COORD_W:0]   c_H_ACT_W   = (COORD_W+1)'(H_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEAD = 2'd1,
        S_RUN  = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic [COORD_W-1:0] h_inc, v_inc;
    logic               last_px;

    logic               hsync_q, vsync_q, valid_h_q, pre_q, valid_v_q, de_q;
    logic               vf_q, fs_q, ls_q, running_q;
    logic [FRAME_W-1:0] frame_cnt_q;

    logic               hsync_d, vsync_d, valid_h_d, pre_d, valid_v_d, de_d;
    logic               vf_d, fs_d, ls_d, active_d;
    logic [COORD_W:0]   ahead_h;
    logic [COORD_W-1:0] ahead_v;

    always_comb begin
        h_inc   = (h_q == c_H_LAST) ? '0 : h_q + 1'b1;
        v_inc   = v_q;
        if (h_q == c_H_LAST) begin
            v_inc = (v_q == c_V_LAST) ? '0 : v_q + 1'b1;
        end
        last_px = (h_q == c_H_LAST) && (v_q == c_V_LAST);
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_LEAD;
                    h_d     = c_LEAD_H;
                    v_d     = c_V_LAST;
                end
            end
            S_LEAD: begin
                h_d = h_inc;
                v_d = v_inc;
                // The frame that LEAD announced always starts, even if en has dropped
                if (last_px) begin
                    state_d = en ? S_RUN : S_STOP;
                end
            end
            S_RUN: begin
                if (last_px && !en) begin
                    state_d = S_IDLE;
                    h_d     = '0;
                    v_d     = '0;
                end else begin
                    h_d = h_inc;
                    v_d = v_inc;
                    if (!en) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (en) begin
                    state_d = S_RUN;
                    h_d     = h_inc;
                    v_d     = v_inc;
                end else if (last_px) begin
                    state_d = S_IDLE;
                    h_d     = '0;
                    v_d     = '0;
                end else begin
                    h_d = h_inc;
                    v_d = v_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next (state, h, v) so they register alongside the counters
    always_comb begin
        ahead_h = {1'b0, h_d} + c_LEAD_W;
        ahead_v = v_d;
        if (ahead_h >= c_H_TOTAL_W) begin
            ahead_h = ahead_h - c_H_TOTAL_W;
            ahead_v = (v_d == c_V_LAST) ? '0 : v_d + 1'b1;
        end
        active_d  = (state_d != S_IDLE);
        valid_h_d = active_d && (h_d < c_H_ACT);
        valid_v_d = active_d && (v_d < c_V_ACT);
        de_d      = valid_h_d && valid_v_d;
        pre_d     = active_d && (ahead_h < c_H_ACT_W) && (ahead_v < c_V_ACT);
        hsync_d   = (active_d && (h_d >= c_HS_START) && (h_d < c_HS_END)) ? HS_POL : ~HS_POL;
        vsync_d   = (active_d && (v_d >= c_VS_START) && (v_d < c_VS_END)) ? VS_POL : ~VS_POL;
        vf_d      = (state_d == S_RUN) || (state_d == S_STOP);
        fs_d      = vf_d && (h_d == '0) && (v_d == '0);
        ls_d      = active_d && (h_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            h_q         <= '0;
            v_q         <= '0;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            valid_h_q   <= 1'b0;
            pre_q       <= 1'b0;
            valid_v_q   <= 1'b0;
            de_q        <= 1'b0;
            vf_q        <= 1'b0;
            fs_q        <= 1'b0;
            ls_q        <= 1'b0;
            running_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            valid_h_q <= valid_h_d;
            pre_q     <= pre_d;
            valid_v_q <= valid_v_d;
            de_q      <= de_d;
            vf_q      <= vf_d;
            fs_q      <= fs_d;
            ls_q      <= ls_d;
            running_q <= active_d;
            if (fs_d) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign video_hsync_o       = hsync_q;
    assign video_vsync_o       = vsync_q;
    assign video_valid_h_o     = valid_h_q;
    assign pre_video_valid_h_o = pre_q;
    assign video_valid_v_o     = valid_v_q;
    assign video_de_o          = de_q;
    assign valid_frame         = vf_q;
    assign frame_start_o       = fs_q;
    assign line_start_o        = ls_q;
    assign running             = running_q;
    assign x                   = h_q;
    assign y                   = v_q;
    assign frame_cnt           = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_gen
// Brief    : Self-checking bench for video_timing_gen against a frame-position model.
// Revision : 1.0
// ============================================================================
module tb_video_timing_gen;

    localparam int   HA  = 8;
    localparam int   HFP = 2;
    localparam int   HS  = 2;
    localparam int   HBP = 2;
    localparam int   VA  = 4;
    localparam int   VFP = 1;
    localparam int   VS  = 1;
    localparam int   VBP = 1;
    localparam bit   HSP = 1'b0;
    localparam bit   VSP = 1'b1;
    localparam int   PL  = 2;
    localparam int   HT  = HA + HFP + HS + HBP;
    localparam int   VT  = VA + VFP + VS + VBP;
    localparam int   FT  = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        hsync, vsync, vh, pre, vv, de, vf, fs, ls, run;
    logic [15:0] x, y, fc;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: generation is a single position counter over the frame, negative during lead-in
    bit m_act = 1'b0;
    int m_pos = 0;
    int m_fc  = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .PRE_LEAD(PL), .COORD_W(16), .FRAME_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .video_hsync_o(hsync), .video_vsync_o(vsync),
        .video_valid_h_o(vh), .pre_video_valid_h_o(pre),
        .video_valid_v_o(vv), .video_de_o(de), .valid_frame(vf),
        .frame_start_o(fs), .line_start_o(ls), .running(run),
        .x(x), .y(y), .frame_cnt(fc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit e);
        if (r) begin
            m_act = 1'b0; m_pos = 0; m_fc = 0;
        end else if (!m_act) begin
            if (e) begin
                m_act = 1'b1; m_pos = -PL;
            end
        end else if (m_pos == FT - 1) begin
            if (e) begin
                m_pos = 0; m_fc = (m_fc + 1) % 65536;
            end else begin
                m_act = 1'b0; m_pos = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == 0) m_fc = (m_fc + 1) % 65536;
        end
    endtask

    task automatic check_all();
        int h, v, pp;
        bit e_vh, e_vv, e_pre, e_hs, e_vs, e_vf;
        h = 0; v = 0; e_vh = 0; e_vv = 0; e_pre = 0; e_hs = 0; e_vs = 0; e_vf = 0;
        if (m_act) begin
            if (m_pos < 0) begin
                h = HT + m_pos; v = VT - 1;
            end else begin
                h = m_pos % HT; v = m_pos / HT;
            end
            e_vh  = (h < HA);
            e_vv  = (v < VA);
            e_hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
            e_vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
            e_vf  = (m_pos >= 0);
            pp    = m_pos + PL;
            if (pp >= FT) pp -= FT;
            e_pre = ((pp % HT) < HA) && ((pp / HT) < VA);
        end
        chk("running", run, m_act);
        chk("x", x, h);
        chk("y", y, v);
        chk("frame_cnt", fc, m_fc);
        chk("valid_h", vh, e_vh);
        chk("valid_v", vv, e_vv);
        chk("de", de, e_vh && e_vv);
        chk("pre_valid_h", pre, e_pre);
        chk("hsync", hsync, e_hs ? HSP : !HSP);
        chk("vsync", vsync, e_vs ? VSP : !VSP);
        chk("valid_frame", vf, e_vf);
        chk("frame_start", fs, m_act && m_pos == 0);
        chk("line_start", ls, m_act && h == 0);
    endtask

    task automatic tick(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge clk);
        model_step(r, e);
        #1;
        cyc++;
        check_all();
    endtask

    typedef struct {
        bit r;
        bit e;
        int n;
        bit run;
        int fc;
        int x;
        int y;
    } vec_t;

    vec_t tbl[24];

    initial begin
        int t_run, t_fs1, t_fs2, n_de, n_vf, n_vs;
        bit en_r;

        tbl[0]  = '{1'b1, 1'b0,  3, 1'b0, 0,  0, 0};
        tbl[1]  = '{1'b0, 1'b1,  1, 1'b1, 0, 12, 6};
        tbl[2]  = '{1'b0, 1'b1,  2, 1'b1, 1,  0, 0};
        tbl[3]  = '{1'b0, 1'b1, 98, 1'b1, 2,  0, 0};
        tbl[4]  = '{1'b0, 1'b1, 98, 1'b1, 3,  0, 0};
        tbl[5]  = '{1'b0, 1'b1, 14, 1'b1, 3,  0, 1};
        tbl[6]  = '{1'b0, 1'b0, 83, 1'b1, 3, 13, 6};
        tbl[7]  = '{1'b0, 1'b0,  1, 1'b0, 3,  0, 0};
        tbl[8]  = '{1'b0, 1'b0,  5, 1'b0, 3,  0, 0};
        tbl[9]  = '{1'b0, 1'b1,  1, 1'b1, 3, 12, 6};
        tbl[10] = '{1'b0, 1'b1,  2, 1'b1, 4,  0, 0};
        tbl[11] = '{1'b0, 1'b1, 28, 1'b1, 4,  0, 2};
        tbl[12] = '{1'b0, 1'b0, 42, 1'b1, 4,  0, 5};
        tbl[13] = '{1'b0, 1'b1, 28, 1'b1, 5,  0, 0};
        tbl[14] = '{1'b0, 1'b1, 32, 1'b1, 5,  4, 2};
        tbl[15] = '{1'b1, 1'b1,  1, 1'b0, 0,  0, 0};
        tbl[16] = '{1'b0, 1'b1,  1, 1'b1, 0, 12, 6};
        tbl[17] = '{1'b0, 1'b1,  2, 1'b1, 1,  0, 0};
        tbl[18] = '{1'b0, 1'b0, 97, 1'b1, 1, 13, 6};
        tbl[19] = '{1'b0, 1'b0,  1, 1'b0, 1,  0, 0};
        tbl[20] = '{1'b0, 1'b1,  1, 1'b1, 1, 12, 6};
        tbl[21] = '{1'b0, 1'b0,  2, 1'b1, 2,  0, 0};
        tbl[22] = '{1'b0, 1'b0, 97, 1'b1, 2, 13, 6};
        tbl[23] = '{1'b0, 1'b0,  1, 1'b0, 2,  0, 0};

        // Start-up latency, frame period and per-frame strobe totals
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        t_run = -1; t_fs1 = -1; t_fs2 = -1; n_de = 0; n_vf = 0; n_vs = 0;
        for (int i = 1; i <= 300 && t_fs2 < 0; i++) begin
            tick(1'b0, 1'b1);
            if (run && t_run < 0) t_run = i;
            if (fs) begin
                if (t_fs1 < 0) t_fs1 = i;
                else           t_fs2 = i;
            end
            if (t_fs1 >= 0 && t_fs2 < 0) begin
                n_de += int'(de);
                n_vf += int'(vf);
                n_vs += int'(vsync == VSP);
            end
        end
        chk("en_to_running", t_run, 1);
        chk("en_to_frame_start", t_fs1, 3);
        chk("frame_period", t_fs2 - t_fs1, FT);
        chk("de_per_frame", n_de, HA * VA);
        chk("valid_frame_per_frame", n_vf, FT);
        chk("vsync_per_frame", n_vs, HT * VS);

        for (int k = 0; k < 24; k++) begin
            for (int j = 0; j < tbl[k].n; j++) tick(tbl[k].r, tbl[k].e);
            chk($sformatf("vec%0d_running", k), run, tbl[k].run);
            chk($sformatf("vec%0d_frame_cnt", k), fc, tbl[k].fc);
            chk($sformatf("vec%0d_x", k), x, tbl[k].x);
            chk($sformatf("vec%0d_y", k), y, tbl[k].y);
        end

        // Randomised run/stop/reset activity against the model
        en_r = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            tick($urandom_range(0, 999) == 0, en_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
